fd_pipe_reg: RTL and testbench

//  F/D pipeline register of the 5-stage MIPS core. Captures fetch-stage PC, instruction word,

---
 rtl/fd_pipe_reg_if.sv | 43 ++++
 rtl/fd_pipe_reg.sv | 75 +++++++
 tb/tb_fd_pipe_reg.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fd_pipe_reg_if.sv
// F/D pipeline register bus: F-stage capture inputs, stage controls and D-stage outputs.
// Optional feature macro: FD_STALL_CNT_EN adds D_stall_cnt (stall cycle counter).
interface fd_pipe_reg_if;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned IW_W  = 32;
  localparam int unsigned EXC_W = 5;

  logic             D_REGen;
  logic             req;
  logic             eret_clr;
  logic [PC_W-1:0]  F_PC;
  logic [IW_W-1:0]  F_instr;
  logic [EXC_W-1:0] F_ExcCode;
  logic             F_BD;
  logic [PC_W-1:0]  D_PC;
  logic [IW_W-1:0]  D_instr;
  logic [EXC_W-1:0] D_ExcCode;
  logic             D_BD;
  logic             D_valid;
`ifdef FD_STALL_CNT_EN
  logic [31:0]      D_stall_cnt;

  modport master (
    output D_REGen, req, eret_clr, F_PC, F_instr, F_ExcCode, F_BD,
    input  D_PC, D_instr, D_ExcCode, D_BD, D_valid, D_stall_cnt
  );

  modport slave (
    input  D_REGen, req, eret_clr, F_PC, F_instr, F_ExcCode, F_BD,
    output D_PC, D_instr, D_ExcCode, D_BD, D_valid, D_stall_cnt
  );
`else
  modport master (
    output D_REGen, req, eret_clr, F_PC, F_instr, F_ExcCode, F_BD,
    input  D_PC, D_instr, D_ExcCode, D_BD, D_valid
  );

  modport slave (
    input  D_REGen, req, eret_clr, F_PC, F_instr, F_ExcCode, F_BD,
    output D_PC, D_instr, D_ExcCode, D_BD, D_valid
  );
`endif
endinterface

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register of the 5-stage MIPS core: captures F-stage PC, instruction,
// fetch exception code and delay-slot flag; supports stall, flush, eret squash and
// nop-ing of faulting fetches.
// Optional feature macro: FD_STALL_CNT_EN adds a saturating stall-cycle counter.
module fd_pipe_reg #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic          clk,
  input  logic          reset,
  fd_pipe_reg_if.slave  bus
);
  localparam int unsigned PC_W  = 32;
  localparam int unsigned IW_W  = 32;
  localparam int unsigned EXC_W = 5;
  localparam int unsigned CNT_W = 32;

  logic [PC_W-1:0]  pc_q;
  logic [IW_W-1:0]  instr_q;
  logic [EXC_W-1:0] exc_q;
  logic             bd_q;
  logic             valid_q;

  // Stage register; priority reset > flush > stall > eret squash > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      instr_q <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.req) begin
      pc_q    <= EXC_ENTRY;
      instr_q <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.D_REGen) begin
      pc_q <= bus.F_PC;
      if (bus.eret_clr) begin
        instr_q <= '0;
        exc_q   <= '0;
        bd_q    <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        // A faulting fetch is forwarded as a nop so its bits are never decoded.
        instr_q <= (bus.F_ExcCode != '0) ? '0 : bus.F_instr;
        exc_q   <= bus.F_ExcCode;
        bd_q    <= bus.F_BD;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.D_PC      = pc_q;
  assign bus.D_instr   = instr_q;
  assign bus.D_ExcCode = exc_q;
  assign bus.D_BD      = bd_q;
  assign bus.D_valid   = valid_q;

`ifdef FD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of stalled cycles; flush neither counts nor clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (!bus.req && !bus.D_REGen && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.D_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed self-checking bench for fd_pipe_reg.
// Optional feature macro: FD_STALL_CNT_EN also checks the stall counter.
module tb_fd_pipe_reg;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fd_pipe_reg_if bus ();

  fd_pipe_reg #(
    .PC_RESET  (32'h0000_3000),
    .EXC_ENTRY (32'h0000_4180)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic rq, input logic er,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic [4:0] exc, input logic bd);
    bus.D_REGen   = en;
    bus.req       = rq;
    bus.eret_clr  = er;
    bus.F_PC      = pc;
    bus.F_instr   = ins;
    bus.F_ExcCode = exc;
    bus.F_BD      = bd;
  endtask

  task automatic check_d(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [4:0] exc, input logic bd, input logic vld);
    check({tag, ".pc"},    bus.D_PC,              pc);
    check({tag, ".instr"}, bus.D_instr,           ins);
    check({tag, ".exc"},   32'(bus.D_ExcCode),    32'(exc));
    check({tag, ".bd"},    32'(bus.D_BD),         32'(bd));
    check({tag, ".valid"}, 32'(bus.D_valid),      32'(vld));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_1111, 32'hDEAD_BEEF, 5'd0, 1'b1);
    tick();
    check_d("reset", 32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0);
`ifdef FD_STALL_CNT_EN
    check("reset.cnt", bus.D_stall_cnt, 32'd0);
`endif

    // Plain load of a delay-slot instruction.
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3004, 32'h3C01_1234, 5'd0, 1'b1);
    tick();
    check_d("load", 32'h0000_3004, 32'h3C01_1234, 5'd0, 1'b1, 1'b1);

    // Load then stall three cycles while F keeps changing.
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3008, 32'h2402_0001, 5'd0, 1'b0);
    tick();
    check_d("load2", 32'h0000_3008, 32'h2402_0001, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0000_5000 + 32'(i * 4), 32'hFFFF_0000 + 32'(i), 5'd4, 1'b1);
      tick();
      check_d("stall", 32'h0000_3008, 32'h2402_0001, 5'd0, 1'b0, 1'b1);
    end
`ifdef FD_STALL_CNT_EN
    check("stall.cnt", bus.D_stall_cnt, 32'd3);
`endif

    // Flush during stall.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_300C, 32'h1234_5678, 5'd0, 1'b1);
    tick();
    check_d("flush", 32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0);
`ifdef FD_STALL_CNT_EN
    check("flush.cnt", bus.D_stall_cnt, 32'd3);
`endif

    // Faulting fetch: PC and code pass, instruction becomes nop.
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3001, 32'hFFFF_FFFF, 5'd4, 1'b0);
    tick();
    check_d("adel", 32'h0000_3001, 32'h0, 5'd4, 1'b0, 1'b1);

    // eret squash.
    drive(1'b1, 1'b0, 1'b1, 32'h0000_300C, 32'h0000_1234, 5'd0, 1'b1);
    tick();
    check_d("eret", 32'h0000_300C, 32'h0, 5'd0, 1'b0, 1'b0);

    // eret together with req: flush wins.
    drive(1'b1, 1'b1, 1'b1, 32'h0000_3010, 32'h0000_5678, 5'd0, 1'b1);
    tick();
    check_d("eret_req", 32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0);

    // Load, then reset while stalled and flushing: reset wins.
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3014, 32'h0062_0821, 5'd0, 1'b1);
    tick();
    check_d("load3", 32'h0000_3014, 32'h0062_0821, 5'd0, 1'b1, 1'b1);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_3018, 32'h0000_0001, 5'd4, 1'b1);
    tick();
    check_d("rst_win", 32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0);
`ifdef FD_STALL_CNT_EN
    check("rst_win.cnt", bus.D_stall_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
